// File: rtl/uart_tcm_loader.sv
// uart_tcm_loader
//   Boot-time image loader. Parses a framed program image from the UART byte
//   stream and writes little-endian 32-bit words into the TCM. The core is
//   held in reset until a complete, checksum-valid image has been written.
//
//   Frame: MAGIC, LEN_LO, LEN_HI, 4*LEN data bytes, CSUM
//          CSUM = (LEN_LO + LEN_HI + all data bytes) mod 256
//
// Ports
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   rx_data_i    received UART byte
//   rx_valid_i   rx_data_i valid (transfer when rx_valid_i && rx_ready_o)
//   rx_ready_o   loader can accept a byte (low while a TCM write is pending)
//   mem_we_o     TCM write request
//   mem_addr_o   TCM word address
//   mem_wdata_o  TCM write data
//   mem_ready_i  TCM accepted the write this cycle
//   core_rstn_o  core reset, released only after a good image
//   done_o       image loaded and checksum OK (sticky until rstn_i)
//   err_o        frame error (length, checksum or timeout)
//   words_o      words written in current/last frame
module uart_tcm_loader #(
    parameter int          MEM_WORDS   = 16384,
    parameter int          ADDR_W      = 14,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              core_rstn_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       words_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    // Counter value at which the next idle cycle completes the timeout.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // Modular 8-bit checksum accumulate.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    logic [2:0]        state_r,     state_next_s;
    logic [15:0]       len_r,       len_next_s;
    logic [7:0]        csum_r,      csum_next_s;
    logic [1:0]        byte_idx_r,  byte_idx_next_s;
    logic [23:0]       word_r,      word_next_s;
    logic [15:0]       words_r,     words_next_s;
    logic [TO_W-1:0]   to_cnt_r,    to_cnt_next_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_next_s;
    logic [31:0]       mem_wdata_r, mem_wdata_next_s;
    logic              mem_we_r;
    logic              rx_ready_r;
    logic              core_rstn_r;
    logic              done_r;
    logic              err_r;

    logic              byte_acc_s;
    logic [15:0]       len_cat_s;
    logic              len_too_big_s;
    logic              to_hit_s;

    assign byte_acc_s    = rx_valid_i && rx_ready_r;
    assign len_cat_s     = {rx_data_i, len_r[7:0]};
    assign len_too_big_s = ({16'd0, len_cat_s} > 32'(MEM_WORDS));
    assign to_hit_s      = (to_cnt_r == TO_LAST);

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_next_s     = state_r;
        len_next_s       = len_r;
        csum_next_s      = csum_r;
        byte_idx_next_s  = byte_idx_r;
        word_next_s      = word_r;
        words_next_s     = words_r;
        to_cnt_next_s    = to_cnt_r;
        mem_addr_next_s  = mem_addr_r;
        mem_wdata_next_s = mem_wdata_r;

        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (byte_acc_s && (rx_data_i == MAGIC)) begin
                    state_next_s    = ST_LEN0;
                    csum_next_s     = 8'd0;
                    words_next_s    = 16'd0;
                    byte_idx_next_s = 2'd0;
                    to_cnt_next_s   = '0;
                end else begin
                    to_cnt_next_s   = '0;
                end
            end
            ST_LEN0: begin
                if (byte_acc_s) begin
                    len_next_s[7:0] = rx_data_i;
                    csum_next_s     = csum_add(csum_r, rx_data_i);
                    to_cnt_next_s   = '0;
                    state_next_s    = ST_LEN1;
                end else if (to_hit_s) begin
                    state_next_s    = ST_ERR;
                end else begin
                    to_cnt_next_s   = to_cnt_r + 1'b1;
                end
            end
            ST_LEN1: begin
                if (byte_acc_s) begin
                    len_next_s    = len_cat_s;
                    csum_next_s   = csum_add(csum_r, rx_data_i);
                    to_cnt_next_s = '0;
                    if (len_too_big_s) begin
                        state_next_s = ST_ERR;
                    end else if (len_cat_s == 16'd0) begin
                        state_next_s = ST_CSUM;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else if (to_hit_s) begin
                    state_next_s  = ST_ERR;
                end else begin
                    to_cnt_next_s = to_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (byte_acc_s) begin
                    csum_next_s     = csum_add(csum_r, rx_data_i);
                    to_cnt_next_s   = '0;
                    byte_idx_next_s = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    word_next_s[7:0]   = rx_data_i;
                        2'd1:    word_next_s[15:8]  = rx_data_i;
                        2'd2:    word_next_s[23:16] = rx_data_i;
                        2'd3: begin
                            mem_wdata_next_s = {rx_data_i, word_r};
                            mem_addr_next_s  = words_r[ADDR_W-1:0];
                            state_next_s     = ST_WRITE;
                        end
                        default: state_next_s = ST_ERR;
                    endcase
                end else if (to_hit_s) begin
                    state_next_s  = ST_ERR;
                end else begin
                    to_cnt_next_s = to_cnt_r + 1'b1;
                end
            end
            ST_WRITE: begin
                // Timeout counter is frozen here: a stalled TCM must not abort.
                if (mem_ready_i) begin
                    words_next_s = words_r + 16'd1;
                    if ((words_r + 16'd1) == len_r) begin
                        state_next_s = ST_CSUM;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_CSUM: begin
                if (byte_acc_s) begin
                    to_cnt_next_s = '0;
                    if (rx_data_i == csum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else if (to_hit_s) begin
                    state_next_s  = ST_ERR;
                end else begin
                    to_cnt_next_s = to_cnt_r + 1'b1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from next state).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= ST_IDLE;
            len_r       <= 16'd0;
            csum_r      <= 8'd0;
            byte_idx_r  <= 2'd0;
            word_r      <= 24'd0;
            words_r     <= 16'd0;
            to_cnt_r    <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            mem_we_r    <= 1'b0;
            rx_ready_r  <= 1'b0;
            core_rstn_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            len_r       <= len_next_s;
            csum_r      <= csum_next_s;
            byte_idx_r  <= byte_idx_next_s;
            word_r      <= word_next_s;
            words_r     <= words_next_s;
            to_cnt_r    <= to_cnt_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            mem_we_r    <= (state_next_s == ST_WRITE);
            rx_ready_r  <= (state_next_s != ST_WRITE);
            core_rstn_r <= (state_next_s == ST_DONE);
            done_r      <= (state_next_s == ST_DONE);
            err_r       <= (state_next_s == ST_ERR);
        end
    end

    assign rx_ready_o  = rx_ready_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign core_rstn_o = core_rstn_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign words_o     = words_r;

endmodule

// File: tb/tb_uart_tcm_loader.sv
// Self-checking bench for uart_tcm_loader: table of frames plus hand-written
// sequences for TCM stall, length error, timeout and reset mid-frame.
// Expected TCM writes go to a queue when a frame is sent and are popped by a
// monitor when the DUT performs the write handshake.
module tb_uart_tcm_loader;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        core_rstn;
    logic        done;
    logic        err;
    logic [15:0] words;

    always #5 clk = ~clk;

    uart_tcm_loader #(
        .MEM_WORDS(16384), .ADDR_W(14), .TIMEOUT_CYC(TO), .MAGIC(8'hA5)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .core_rstn_o(core_rstn),
        .done_o(done), .err_o(err), .words_o(words)
    );

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        logic [31:0] w [3];
        logic [7:0]  csum_flip;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs [5];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Write monitor: a write is accepted at the next rising edge.
    always @(negedge clk) begin
        if (rstn && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, none expected", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_total++;
            $display("FAIL byte_accept: byte 0x%02h never accepted, expected acceptance", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_body(input vec_t v);
        logic [7:0] cs;
        logic [7:0] d;
        cs = v.len[7:0] + v.len[15:8];
        send_byte(v.len[7:0]);
        send_byte(v.len[15:8]);
        for (int i = 0; i < int'(v.len); i++) begin
            exp_q.push_back('{addr: i[13:0], data: v.w[i]});
            for (int b = 0; b < 4; b++) begin
                d  = v.w[i][8*b +: 8];
                cs = cs + d;
                send_byte(d);
            end
        end
        send_byte(cs ^ v.csum_flip);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        mem_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_core_rstn",32'(core_rstn),32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_words",    32'(words),    32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    logic stable;

    initial begin
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mem_ready = 1'b1;

        vecs[0] = '{len: 16'd2, w: '{32'h12345678, 32'hDEADBEEF, 32'h0}, csum_flip: 8'h00,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2};
        vecs[1] = '{len: 16'd2, w: '{32'h12345678, 32'hDEADBEEF, 32'h0}, csum_flip: 8'h01,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd2};
        vecs[2] = '{len: 16'd0, w: '{32'h0, 32'h0, 32'h0}, csum_flip: 8'h00,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd0};
        vecs[3] = '{len: 16'd1, w: '{32'hCAFEF00D, 32'h0, 32'h0}, csum_flip: 8'h00,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd1};
        vecs[4] = '{len: 16'd3, w: '{32'h00000001, 32'hFFFFFFFF, 32'h80A5A500}, csum_flip: 8'h80,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd3};

        // Table-driven frames, each from a fresh reset.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            send_byte(8'hA5);
            send_body(vecs[k]);
            chk($sformatf("v%0d_done", k),      32'(done),      32'(vecs[k].exp_done));
            chk($sformatf("v%0d_core_rstn", k), 32'(core_rstn), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_err", k),       32'(err),       32'(vecs[k].exp_err));
            chk($sformatf("v%0d_words", k),     32'(words),     32'(vecs[k].exp_words));
            chk($sformatf("v%0d_sb_empty", k),  32'(exp_q.size()), 32'd0);
        end

        // Bad checksum then correct resend: err clears at MAGIC.
        do_reset();
        send_byte(8'hA5);
        send_body(vecs[1]);
        chk("bad_err", 32'(err), 32'd1);
        send_byte(8'h33);
        chk("err_ignores_garbage", 32'(err), 32'd1);
        send_byte(8'hA5);
        chk("resend_err_clear", 32'(err), 32'd0);
        send_body(vecs[0]);
        chk("resend_done", 32'(done), 32'd1);
        chk("resend_core_rstn", 32'(core_rstn), 32'd1);
        send_byte(8'hA5);
        chk("done_sticky", 32'(done), 32'd1);
        chk("done_words_kept", 32'(words), 32'd2);

        // TCM stall longer than the timeout on word 0.
        do_reset();
        mem_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        exp_q.push_back('{addr: 14'd0, data: 32'h12345678});
        exp_q.push_back('{addr: 14'd1, data: 32'hDEADBEEF});
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        stable = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            rx_data  = 8'hEF;
            rx_valid = 1'b1;
            if (!(mem_we && mem_addr == 14'd0 && mem_wdata == 32'h12345678 && !rx_ready && !err))
                stable = 1'b0;
        end
        chk("stall_stable", 32'(stable), 32'd1);
        chk("stall_words", 32'(words), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_handshake_words", 32'(words), 32'd1);
        chk("stall_we_drop", 32'(mem_we), 32'd0);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h4E);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Oversized length: error right after LEN_HI, no writes.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01);
        chk("len_no_err_yet", 32'(err), 32'd0);
        send_byte(8'h40);
        chk("len_err", 32'(err), 32'd1);
        chk("len_words", 32'(words), 32'd0);
        repeat (4) @(negedge clk);
        chk("len_core_rstn", 32'(core_rstn), 32'd0);

        // Timeout: garbage ignored, then silence after LEN_LO.
        do_reset();
        send_byte(8'h11); send_byte(8'h22);
        chk("garbage_err", 32'(err), 32'd0);
        send_byte(8'hA5); send_byte(8'h03);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("to_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("to_at", 32'(err), 32'd1);

        // Asynchronous reset in the middle of DATA.
        do_reset();
        exp_q.push_back('{addr: 14'd0, data: 32'h12345678});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE);
        chk("mid_words", 32'(words), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_rx_ready", 32'(rx_ready), 32'd0);
        chk("arst_mem_we",   32'(mem_we),   32'd0);
        chk("arst_addr",     32'(mem_addr), 32'd0);
        chk("arst_wdata",    mem_wdata,     32'd0);
        chk("arst_words",    32'(words),    32'd0);
        chk("arst_err",      32'(err),      32'd0);
        do_reset();
        send_byte(8'hA5);
        send_body(vecs[0]);
        chk("after_rst_done", 32'(done), 32'd1);
        chk("after_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
